// File: rtl/apb_wait_slave.sv
// APB completer with a local word array, WAIT_STATES inserted wait cycles per access,
// and an optional out-of-range error response enabled by APB_SLV_PSLVERR_EN.
module apb_wait_slave #(
  parameter int WADDR       = 8,
  parameter int WDATA       = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic             i_PCLK,
  input  logic             i_PRESETn,
  input  logic             i_PSEL,
  input  logic             i_PENABLE,
  input  logic             i_PWRITE,
  input  logic [WADDR-1:0] i_PADDR,
  input  logic [WDATA-1:0] i_PWDATA,
  output logic [WDATA-1:0] o_PRDATA,
  output logic             o_PREADY,
  output logic             o_PSLVERR
);

  // state    | meaning
  // S_IDLE   | no transfer in flight, waiting for a SETUP cycle
  // S_ACCESS | transfer latched, counting wait states then completing
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic [0:0]       state;
  logic [3:0]       wait_cnt;
  logic [WADDR-1:0] addr_q;
  logic             write_q;
  logic [WDATA-1:0] wdata_q;
  logic             oor_q;
  logic [WDATA-1:0] mem [DEPTH];

  logic setup;
  logic in_range;
  logic err_next;

  assign setup    = i_PSEL & ~i_PENABLE;
  assign in_range = (32'(i_PADDR) < 32'(DEPTH));

`ifdef APB_SLV_PSLVERR_EN
  assign err_next = ~in_range;
`else
  assign err_next = 1'b0;
`endif

  // A SETUP is taken in either state: from ACCESS it silently drops the old transfer.
  always_ff @(posedge i_PCLK) begin
    if (!i_PRESETn) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      oor_q     <= 1'b0;
      o_PRDATA  <= '0;
      o_PREADY  <= 1'b0;
      o_PSLVERR <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (setup) begin
      state     <= S_ACCESS;
      addr_q    <= i_PADDR;
      write_q   <= i_PWRITE;
      wdata_q   <= i_PWDATA;
      oor_q     <= ~in_range;
      wait_cnt  <= WAIT_INIT;
      o_PREADY  <= (WAIT_STATES == 0);
      o_PSLVERR <= err_next;
      o_PRDATA  <= (in_range && !i_PWRITE) ? mem[i_PADDR] : '0;
    end else if (state == S_ACCESS) begin
      if (!i_PSEL) begin
        o_PREADY  <= 1'b0;
        o_PSLVERR <= 1'b0;
        state     <= S_IDLE;
      end else if (!o_PREADY) begin
        wait_cnt <= wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) o_PREADY <= 1'b1;
      end else begin
        if (write_q && !oor_q) mem[addr_q] <= wdata_q;
        o_PREADY  <= 1'b0;
        o_PSLVERR <= 1'b0;
        state     <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_apb_wait_slave.sv
// Directed bench for apb_wait_slave: three instances (default, zero-wait, DEPTH=192)
// share one APB bus with per-instance PSEL.
module tb_apb_wait_slave;

  logic       clk;
  logic       rst_b;
  logic       psel [3];
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata [3];
  logic       pready [3];
  logic       pslverr [3];

  int checks = 0;
  int errors = 0;

`ifdef APB_SLV_PSLVERR_EN
  localparam logic EXP_OOR_ERR = 1'b1;
`else
  localparam logic EXP_OOR_ERR = 1'b0;
`endif

  apb_wait_slave u_dut_def (
    .i_PCLK(clk), .i_PRESETn(rst_b), .i_PSEL(psel[0]), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata),
    .o_PRDATA(prdata[0]), .o_PREADY(pready[0]), .o_PSLVERR(pslverr[0])
  );

  apb_wait_slave #(.WAIT_STATES(0)) u_dut_w0 (
    .i_PCLK(clk), .i_PRESETn(rst_b), .i_PSEL(psel[1]), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata),
    .o_PRDATA(prdata[1]), .o_PREADY(pready[1]), .o_PSLVERR(pslverr[1])
  );

  apb_wait_slave #(.DEPTH(192)) u_dut_d192 (
    .i_PCLK(clk), .i_PRESETn(rst_b), .i_PSEL(psel[2]), .i_PENABLE(penable),
    .i_PWRITE(pwrite), .i_PADDR(paddr), .i_PWDATA(pwdata),
    .o_PRDATA(prdata[2]), .o_PREADY(pready[2]), .o_PSLVERR(pslverr[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Called at a negedge; drives SETUP immediately, returns at the negedge after the completion edge
  // with the bus left in ACCESS so a following call is back-to-back.
  task automatic do_xfer(input int w, input logic wr, input logic [7:0] a, input logic [7:0] a_acc,
                         input logic [7:0] d, output int waits, output logic [7:0] rd_first,
                         output logic [7:0] rd, output logic err, output logic timeout);
    psel[w] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1; paddr = a_acc;
    rd_first = prdata[w]; rd = 8'hxx; err = 1'bx; waits = 0; timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (pready[w]) begin
        rd = prdata[w]; err = pslverr[w]; timeout = 1'b0;
        break;
      end
      waits++;
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic bus_idle();
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    penable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++; if (prdata[i] !== 8'h00) begin errors++; $display("FAIL reset_prdata[%0d] got %h exp 00", i, prdata[i]); end
      checks++; if (pready[i] !== 1'b0) begin errors++; $display("FAIL reset_pready[%0d] got %b exp 0", i, pready[i]); end
      checks++; if (pslverr[i] !== 1'b0) begin errors++; $display("FAIL reset_pslverr[%0d] got %b exp 0", i, pslverr[i]); end
    end
  endtask

  task automatic test_basic();
    int wt; logic [7:0] rf, rd; logic er, to;
    do_xfer(0, 1'b1, 8'hAA, 8'hAA, 8'h18, wt, rf, rd, er, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_wr_timeout got %b exp 0", to); end
    checks++; if (wt !== 2) begin errors++; $display("FAIL basic_wr_waits got %0d exp 2", wt); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_wr_err got %b exp 0", er); end
    bus_idle();
    do_xfer(0, 1'b0, 8'hAA, 8'hAA, 8'h00, wt, rf, rd, er, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL basic_rd_timeout got %b exp 0", to); end
    checks++; if (wt !== 2) begin errors++; $display("FAIL basic_rd_waits got %0d exp 2", wt); end
    checks++; if (rf !== 8'h18) begin errors++; $display("FAIL basic_rd_first got %h exp 18", rf); end
    checks++; if (rd !== 8'h18) begin errors++; $display("FAIL basic_rd_data got %h exp 18", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL basic_rd_err got %b exp 0", er); end
    bus_idle();
  endtask

  task automatic test_back_to_back_zero_wait();
    int wt; logic [7:0] rf, rd; logic er, to;
    do_xfer(1, 1'b1, 8'hBB, 8'hBB, 8'h67, wt, rf, rd, er, to);
    checks++; if (wt !== 0 || to) begin errors++; $display("FAIL w0_wr_bb_waits got %0d exp 0", wt); end
    do_xfer(1, 1'b1, 8'hAA, 8'hAA, 8'h18, wt, rf, rd, er, to);
    checks++; if (wt !== 0 || to) begin errors++; $display("FAIL w0_wr_aa_waits got %0d exp 0", wt); end
    do_xfer(1, 1'b0, 8'hAA, 8'hAA, 8'h00, wt, rf, rd, er, to);
    checks++; if (wt !== 0 || to) begin errors++; $display("FAIL w0_rd_aa_waits got %0d exp 0", wt); end
    checks++; if (rd !== 8'h18) begin errors++; $display("FAIL w0_rd_aa_data got %h exp 18", rd); end
    do_xfer(1, 1'b0, 8'hBB, 8'hBB, 8'h00, wt, rf, rd, er, to);
    checks++; if (wt !== 0 || to) begin errors++; $display("FAIL w0_rd_bb_waits got %0d exp 0", wt); end
    checks++; if (rd !== 8'h67) begin errors++; $display("FAIL w0_rd_bb_data got %h exp 67", rd); end
    bus_idle();
  endtask

  task automatic test_out_of_range();
    int wt; logic [7:0] rf, rd; logic er, to;
    do_xfer(2, 1'b1, 8'hBF, 8'hBF, 8'h5A, wt, rf, rd, er, to);
    checks++; if (er !== 1'b0 || to) begin errors++; $display("FAIL d192_wr_last_err got %b exp 0", er); end
    bus_idle();
    do_xfer(2, 1'b1, 8'hC8, 8'hC8, 8'h55, wt, rf, rd, er, to);
    checks++; if (wt !== 2 || to) begin errors++; $display("FAIL d192_wr_oor_waits got %0d exp 2", wt); end
    checks++; if (er !== EXP_OOR_ERR) begin errors++; $display("FAIL d192_wr_oor_err got %b exp %b", er, EXP_OOR_ERR); end
    bus_idle();
    do_xfer(2, 1'b0, 8'hC8, 8'hC8, 8'h00, wt, rf, rd, er, to);
    checks++; if (wt !== 2 || to) begin errors++; $display("FAIL d192_rd_oor_waits got %0d exp 2", wt); end
    checks++; if (er !== EXP_OOR_ERR) begin errors++; $display("FAIL d192_rd_oor_err got %b exp %b", er, EXP_OOR_ERR); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL d192_rd_oor_data got %h exp 00", rd); end
    bus_idle();
    do_xfer(2, 1'b0, 8'hBF, 8'hBF, 8'h00, wt, rf, rd, er, to);
    checks++; if (rd !== 8'h5A || to) begin errors++; $display("FAIL d192_rd_last_data got %h exp 5a", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL d192_rd_last_err got %b exp 0", er); end
    bus_idle();
  endtask

  task automatic test_abort();
    int wt; logic [7:0] rf, rd; logic er, to;
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h10; pwdata = 8'h99;
    @(negedge clk);
    psel[0] = 1'b0; penable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (pready[0] !== 1'b0) begin errors++; $display("FAIL abort_pready cycle %0d got %b exp 0", i, pready[0]); end
      @(negedge clk);
      penable = 1'b0;
    end
    do_xfer(0, 1'b0, 8'h10, 8'h10, 8'h00, wt, rf, rd, er, to);
    checks++; if (wt !== 2 || to) begin errors++; $display("FAIL abort_rd_waits got %0d exp 2", wt); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL abort_rd_data got %h exp 00", rd); end
    bus_idle();
  endtask

  task automatic test_addr_hold();
    int wt; logic [7:0] rf, rd; logic er, to;
    do_xfer(0, 1'b1, 8'hBB, 8'hBB, 8'h42, wt, rf, rd, er, to);
    bus_idle();
    do_xfer(0, 1'b1, 8'hAA, 8'hBB, 8'h77, wt, rf, rd, er, to);
    checks++; if (wt !== 2 || to) begin errors++; $display("FAIL hold_wr_waits got %0d exp 2", wt); end
    bus_idle();
    do_xfer(0, 1'b0, 8'hAA, 8'hAA, 8'h00, wt, rf, rd, er, to);
    checks++; if (rd !== 8'h77 || to) begin errors++; $display("FAIL hold_rd_aa got %h exp 77", rd); end
    bus_idle();
    do_xfer(0, 1'b0, 8'hBB, 8'hBB, 8'h00, wt, rf, rd, er, to);
    checks++; if (rd !== 8'h42 || to) begin errors++; $display("FAIL hold_rd_bb got %h exp 42", rd); end
    bus_idle();
  endtask

  task automatic test_reset_mid_access();
    int wt; logic [7:0] rf, rd; logic er, to;
    psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h20; pwdata = 8'h3C;
    @(negedge clk);
    penable = 1'b1;
    checks++; if (pready[0] !== 1'b0) begin errors++; $display("FAIL rstmid_wait_pready got %b exp 0", pready[0]); end
    rst_b = 1'b0;
    @(negedge clk);
    checks++; if (prdata[0] !== 8'h00) begin errors++; $display("FAIL rstmid_prdata got %h exp 00", prdata[0]); end
    checks++; if (pready[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pready got %b exp 0", pready[0]); end
    checks++; if (pslverr[0] !== 1'b0) begin errors++; $display("FAIL rstmid_pslverr got %b exp 0", pslverr[0]); end
    rst_b = 1'b1;
    // Bus still shows ACCESS: an idle slave must ignore it.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (pready[0] !== 1'b0) begin errors++; $display("FAIL rstmid_post_pready cycle %0d got %b exp 0", i, pready[0]); end
    end
    bus_idle();
    do_xfer(0, 1'b0, 8'h20, 8'h20, 8'h00, wt, rf, rd, er, to);
    checks++; if (rd !== 8'h00 || to) begin errors++; $display("FAIL rstmid_rd_20 got %h exp 00", rd); end
    bus_idle();
    do_xfer(0, 1'b0, 8'hAA, 8'hAA, 8'h00, wt, rf, rd, er, to);
    checks++; if (rd !== 8'h00 || to) begin errors++; $display("FAIL rstmid_rd_aa_cleared got %h exp 00", rd); end
    bus_idle();
  endtask

  initial begin
    rst_b = 1'b0;
    for (int i = 0; i < 3; i++) psel[i] = 1'b0;
    penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst_b = 1'b1;
    @(negedge clk);
    test_basic();
    test_back_to_back_zero_wait();
    test_out_of_range();
    test_abort();
    test_addr_hold();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_wait_slave.md
# apb_wait_slave

APB completer (responder) with a local register array, a fixed number of inserted wait states, and an optional error response. It sits on the far side of the team's APB master, decodes each SETUP/ACCESS transfer, and holds off completion with PREADY. It lets benches exercise the master against a slave that is not zero-wait-state.

## Interface
- WADDR, 8: PADDR width in bits.
- WDATA, 8: PWDATA/PRDATA width in bits.
- DEPTH, 256: number of implemented words (1..2^WADDR); addresses ≥ DEPTH are out of range.
- WAIT_STATES, 2: wait cycles (PREADY=0) inserted in every ACCESS phase; 0..15.

- i_PCLK  input  1  clock; all logic on rising edge.
- i_PRESETn  input  1  reset, synchronous, active-low.
- i_PSEL  input  1  slave select.
- i_PENABLE  input  1  access-phase strobe.
- i_PWRITE  input  1  1 = write, 0 = read.
- i_PADDR  input  WADDR  word address.
- i_PWDATA  input  WDATA  write data.
- o_PRDATA  output  WDATA  read data, registered.
- o_PREADY  output  1  transfer-complete, registered.
- o_PSLVERR  output  1  error response, registered; valid only with o_PREADY.

## Operation
- States: IDLE, ACCESS.
- IDLE: at an edge with PSEL=1 and PENABLE=0 (SETUP), latch PADDR/PWRITE/PWDATA and go to ACCESS. Load wait counter = WAIT_STATES. Load o_PREADY = (WAIT_STATES==0). Load o_PSLVERR = out-of-range flag. Load o_PRDATA = mem[PADDR] for an in-range read, else 0. PENABLE=1 while in IDLE is ignored.
- ACCESS, PSEL=1, PENABLE=1, o_PREADY=0: decrement counter. Set o_PREADY=1 on the edge where counter goes 1→0.
- ACCESS, PSEL=1, PENABLE=1, o_PREADY=1: transfer completes at this edge.
  - In-range write: mem[latched addr] ← latched PWDATA.
  - o_PREADY←0, o_PSLVERR←0; go to IDLE.
  - o_PRDATA holds its value until the next SETUP.
- ACCESS with PSEL=0: abort. No memory write, o_PREADY←0, o_PSLVERR←0, go to IDLE.
- ACCESS with PSEL=1 and PENABLE=0: treated as a new SETUP. The old transfer is dropped without a write, and the new one is latched as from IDLE.
- Address and write data are used from the SETUP latch. Changes to them during ACCESS are ignored.
- Back-to-back transfers: a SETUP in the cycle after completion is accepted from IDLE with no extra bubble.

## Timing
- Reset (i_PRESETn=0 at a rising edge): state IDLE, counter 0, o_PRDATA=0, o_PREADY=0, o_PSLVERR=0, all mem words 0. Reset overrides any in-flight transfer; no write occurs.
- A transfer takes 1 SETUP cycle + (WAIT_STATES+1) ACCESS cycles.
- With WAIT_STATES=2: SETUP at cycle n; PREADY low in n+1 and n+2; high in n+3; completion edge ends n+3.
- Read data is valid from the first ACCESS cycle through completion.
- A read of an address written in the immediately preceding transfer returns the new data.

## Configuration
- APB_SLV_PSLVERR_EN defined: out-of-range transfers complete with o_PSLVERR=1 and the same wait states. Reads return 0; writes are discarded.
- APB_SLV_PSLVERR_EN undefined: o_PSLVERR is tied 0. Out-of-range transfers still complete normally; writes are discarded and reads return 0.

## Test plan
- Default params: write 0xAA←0x18, then read 0xAA. Each transfer shows PREADY=0 for 2 access cycles, then 1. o_PRDATA=0x18 and PSLVERR=0 during the read access.
- WAIT_STATES=0: writes 0xBB←0x67 then 0xAA←0x18 back-to-back, then reads both. PREADY=1 in the first access cycle of every transfer; reads return 0x67 and 0x18.
- DEPTH=192, APB_SLV_PSLVERR_EN defined: write 0xC8←0x55, then read 0xC8. Both complete with PSLVERR=1; the read returns 0x00. Repeat with the macro undefined: PSLVERR stays 0 and the read still returns 0x00.
- Abort: SETUP write 0x10←0x99, drop PSEL in the first access cycle, then read 0x10. The read returns 0x00, and PREADY never rose for the aborted transfer.
- Reset mid-access: write 0x20←0x3C, assert i_PRESETn=0 during a wait cycle. On the next edge all outputs are 0. After release, a read of 0x20 returns 0x00.
- PADDR changed from 0xAA to 0xBB during ACCESS of a write of 0x77. The write lands at 0xAA; 0xBB is unchanged.
